// File: rtl/bridge_pkg.sv
// Shared types and constants for the byte-serial memory bridge.
package bridge_pkg;

    // Bridge sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_LANES       = 4;
    localparam int TIMEOUT_DEF     = 15;
    localparam int MEM_ADDR_W_DEF  = 12;

    // Pick byte lane k out of a 32-bit word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_bus_bridge_lane_sel.sv
// Priority encoder: lowest enabled lane among the remaining byte enables.
module byte_lane_sel
    import bridge_pkg::*;
(
    input  logic [NUM_LANES-1:0] be_left,
    output logic [1:0]           lane,
    output logic                 any_left
);

    // Lane 0 has highest priority so lanes go out in ascending order.
    always_comb begin
        lane     = 2'd0;
        any_left = |be_left;
        if (be_left[0])      lane = 2'd0;
        else if (be_left[1]) lane = 2'd1;
        else if (be_left[2]) lane = 2'd2;
        else if (be_left[3]) lane = 2'd3;
    end

endmodule

// File: rtl/byte_bus_bridge.sv
// Splits one 32-bit CPU access into single-byte memory transactions and
// reassembles reads little-endian.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a CPU access
// ISSUE | one-cycle byte request for the lowest remaining lane
// WAIT  | waiting for the byte acknowledge, timeout counter running
// DONE  | one-cycle completion pulse, error flag valid
module byte_bus_bridge
    import bridge_pkg::*;
#(
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_write,
    input  logic [31:0]           i_cpu_addr,
    input  logic [31:0]           i_cpu_wdata,
    input  logic [3:0]            i_cpu_be,
    output logic                  o_cpu_ready,
    output logic [31:0]           o_cpu_rdata,
    output logic                  o_cpu_done,
    output logic                  o_cpu_err,
    output logic                  o_mem_request,
    output logic                  o_mem_write,
    output logic [MEM_ADDR_W-1:0] o_mem_address,
    output logic [7:0]            o_mem_data,
    input  logic [7:0]            i_mem_data,
    input  logic                  i_mem_DV
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t                state_q, state_d;
    logic                  write_q;
    logic [MEM_ADDR_W-3:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [TMO_W-1:0]      tmo_cnt_q;

    logic [1:0]            lane;
    logic                  any_left;
    logic [3:0]            be_next;
    logic                  accept;
    logic                  addr_err;
    logic                  lane_done;
    logic                  tmo_hit;

    // Word alignment is implied; the low address bits carry no meaning here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_cpu_addr[1:0];

    byte_lane_sel u_lane_sel (
        .be_left  (be_q),
        .lane     (lane),
        .any_left (any_left)
    );

    assign be_next = be_q & ~(4'b0001 << lane);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        addr_err      = 1'b0;
        lane_done     = 1'b0;
        tmo_hit       = 1'b0;
        o_cpu_ready   = 1'b0;
        o_cpu_done    = 1'b0;
        o_cpu_err     = 1'b0;
        o_mem_request = 1'b0;
        o_mem_write   = 1'b0;
        o_mem_address = '0;
        o_mem_data    = 8'h00;
        case (state_q)
            IDLE: begin
                o_cpu_ready = 1'b1;
                if (i_cpu_req) begin
                    accept = 1'b1;
                    if (i_cpu_addr[31:MEM_ADDR_W] != '0) begin
                        addr_err = 1'b1;
                        state_d  = DONE;
                    end else if (i_cpu_be == 4'b0000) begin
                        state_d  = DONE;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                o_mem_request = 1'b1;
                o_mem_write   = write_q;
                o_mem_address = {addr_q, lane};
                o_mem_data    = lane_byte(wdata_q, lane);
                state_d       = WAIT;
            end
            WAIT: begin
                o_mem_address = {addr_q, lane};
                o_mem_data    = lane_byte(wdata_q, lane);
                if (i_mem_DV) begin
                    lane_done = 1'b1;
                    state_d   = (be_next != 4'b0000) ? ISSUE : DONE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                o_cpu_done = 1'b1;
                o_cpu_err  = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Access context, read reassembly, error flag and WAIT timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            if (accept) begin
                write_q <= i_cpu_write;
                addr_q  <= i_cpu_addr[MEM_ADDR_W-1:2];
                wdata_q <= i_cpu_wdata;
                be_q    <= i_cpu_be;
                rdata_q <= 32'h0;
                err_q   <= addr_err;
            end
            if (state_q == ISSUE) begin
                tmo_cnt_q <= '0;
            end else if (state_q == WAIT && !i_mem_DV) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (lane_done) begin
                be_q <= be_next;
                if (!write_q) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (lane == 2'(k)) rdata_q[8*k +: 8] <= i_mem_data;
                    end
                end
            end
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    assign o_cpu_rdata = rdata_q;

endmodule
